// File: rtl/vdp1_cmd_fetch.sv
// ---------------------------------------------------------------------------
// vdp1_cmd_fetch
//
// Reader side of the VDP1 command-table interface. Walks the command list
// held in VDP1 VRAM, one 16-word table at a time, following END / JP
// (next, assign, call, return) and skip, and hands every drawable table to
// the draw engine over a valid/ready handshake. Also reports EDSR.CEF, COPR
// and LOPR for the register block.
//
// Optional feature (compile-time macro VDP1_CMD_LIMIT_EN):
//   counts the tables visited (drawn + skipped) in the current walk and
//   force-terminates the walk as if END had been read once the count
//   reaches MAX_CMDS. Without the macro a looping list runs until the next
//   START or reset.
//
// Parameters
//   MAX_CMDS   table count that terminates a walk (VDP1_CMD_LIMIT_EN only)
//
// Ports
//   CLK        system clock
//   RST_N      asynchronous active-low reset
//   CE         clock enable; nothing advances while CE=0
//   START      1-cycle draw-start pulse; (re)starts the walk at table 0000
//   VRAM_A     VRAM word address [18:1] = {T,2'b00} + word index
//   VRAM_RD    read request, held with VRAM_A stable until VRAM_RDY
//   VRAM_D     read data, valid with VRAM_RDY
//   VRAM_RDY   1-cycle read acknowledge
//   CMD        current table (16 x 16-bit words, word n at [16n+15:16n]),
//              CTRL/LINK/PMOD/SIZE masked with FF3F/FFFC/9FFF/3FFF
//   CMD_VALID  CMD holds a drawable table
//   CMD_READY  draw engine accepts CMD
//   BUSY       walk in progress
//   CEF        END reached in the current walk
//   COPR       CMDLINK address of the table being processed
//   LOPR       CMDLINK address of the last table handed off or skipped
// ---------------------------------------------------------------------------
module vdp1_cmd_fetch #(
  parameter logic [15:0] MAX_CMDS = 16'd8192
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CE,
  input  logic         START,
  output logic [17:0]  VRAM_A,
  output logic         VRAM_RD,
  input  logic [15:0]  VRAM_D,
  input  logic         VRAM_RDY,
  output logic [255:0] CMD,
  output logic         CMD_VALID,
  input  logic         CMD_READY,
  output logic         BUSY,
  output logic         CEF,
  output logic [15:0]  COPR,
  output logic [15:0]  LOPR
);

  // Walk states
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_CTRL = 3'd1;
  localparam logic [2:0] S_RD_LINK = 3'd2;
  localparam logic [2:0] S_RD_BODY = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;

  // JP[1:0] jump modes
  localparam logic [1:0] JP_NEXT   = 2'b00;
  localparam logic [1:0] JP_ASSIGN = 2'b01;
  localparam logic [1:0] JP_CALL   = 2'b10;
  localparam logic [1:0] JP_RETURN = 2'b11;

  // Word 15 down to word 0; word 5 = SIZE, word 2 = PMOD, word 1 = LINK,
  // word 0 = CTRL. Everything else passes through unchanged.
  localparam logic [255:0] CMD_MASK = {{10{16'hFFFF}}, 16'h3FFF, 16'hFFFF,
                                       16'hFFFF, 16'h9FFF, 16'hFFFC,
                                       16'hFF3F};

  // A table is skipped when JP[2] is set or COMM is not a drawing,
  // clipping or local-coordinate command.
  function automatic logic tbl_skip(input logic [15:0] ctrl);
    logic comm_ok;
    case (ctrl[3:0])
      4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA: comm_ok = 1'b1;
      default:                                               comm_ok = 1'b0;
    endcase
    return ctrl[14] | ~comm_ok;
  endfunction

  logic [2:0]   state_q,   state_d;
  logic [15:0]  t_q,       t_d;        // current table, CMDLINK format
  logic [15:0]  stk_q,     stk_d;      // one-entry return stack
  logic         stk_vld_q, stk_vld_d;
  logic [3:0]   idx_q,     idx_d;      // word index inside the table
  logic [17:0]  addr_q,    addr_d;
  logic         rd_q,      rd_d;
  logic         drain_q,   drain_d;    // waiting out the ack of an aborted read
  logic [255:0] cmd_q,     cmd_d;      // raw table words
  logic         vld_q,     vld_d;
  logic         busy_q,    busy_d;
  logic         cef_q,     cef_d;
  logic [15:0]  copr_q,    copr_d;
  logic [15:0]  lopr_q,    lopr_d;
`ifdef VDP1_CMD_LIMIT_EN
  logic [15:0]  count_q,   count_d;    // tables visited in this walk
`else
  wire          unused_max_cmds = ^MAX_CMDS;
`endif

  logic         vram_ack;
  logic         do_adv;
  logic [15:0]  t_plus4;
  logic [15:0]  link;
  logic [15:0]  adv_t;
  logic [15:0]  adv_stk;
  logic         adv_stk_vld;
  logic         limit_hit;

  assign vram_ack = rd_q & VRAM_RDY;
  assign t_plus4  = t_q + 16'd4;        // wraps FFFC -> 0000
  assign link     = cmd_q[31:16] & 16'hFFFC;

  // Next table address from the stored CTRL/LINK words and the stack.
  always_comb begin
    adv_t       = t_plus4;
    adv_stk     = stk_q;
    adv_stk_vld = stk_vld_q;
    case (cmd_q[13:12])
      JP_ASSIGN: adv_t = link;
      JP_CALL: begin
        adv_t = link;
        // A call with the stack already full keeps the saved return
        // address and degenerates to an assign.
        if (!stk_vld_q) begin
          adv_stk     = t_plus4;
          adv_stk_vld = 1'b1;
        end
      end
      JP_RETURN: begin
        // Return with an empty stack degenerates to next.
        if (stk_vld_q) begin
          adv_t       = stk_q;
          adv_stk_vld = 1'b0;
        end
      end
      default: ;
    endcase
  end

`ifdef VDP1_CMD_LIMIT_EN
  assign limit_hit = (count_q + 16'd1) == MAX_CMDS;
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets its hold value first so no path
    // through the case statement can leave it unassigned (no latches).
    state_d   = state_q;
    t_d       = t_q;
    stk_d     = stk_q;
    stk_vld_d = stk_vld_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    drain_d   = drain_q;
    cmd_d     = cmd_q;
    vld_d     = vld_q;
    busy_d    = busy_q;
    cef_d     = cef_q;
    copr_d    = copr_q;
    lopr_d    = lopr_q;
    do_adv    = 1'b0;
`ifdef VDP1_CMD_LIMIT_EN
    count_d   = count_q;
`endif

    if (CE) begin
      if (START) begin
        // (Re)start wins over anything the current state would do.
        state_d   = S_RD_CTRL;
        t_d       = 16'h0000;
        stk_vld_d = 1'b0;
        idx_d     = 4'd0;
        vld_d     = 1'b0;
        busy_d    = 1'b1;
        cef_d     = 1'b0;
        copr_d    = 16'h0000;
`ifdef VDP1_CMD_LIMIT_EN
        count_d   = 16'd0;
`endif
        if (rd_q && !VRAM_RDY) begin
          // A read is still in flight: keep the request unchanged until it
          // is acknowledged, then throw the data away.
          drain_d = 1'b1;
        end else begin
          drain_d = 1'b0;
          rd_d    = 1'b1;
          addr_d  = 18'd0;
        end
      end else begin
        case (state_q)
          S_RD_CTRL: begin
            if (vram_ack) begin
              if (drain_q) begin
                drain_d = 1'b0;
                addr_d  = {t_q, 2'b00};
              end else begin
                cmd_d[15:0] = VRAM_D;
                if (VRAM_D[15]) begin
                  // END: walk complete, no further reads.
                  cef_d   = 1'b1;
                  busy_d  = 1'b0;
                  rd_d    = 1'b0;
                  state_d = S_IDLE;
                end else if (VRAM_D[13:12] == JP_ASSIGN ||
                             VRAM_D[13:12] == JP_CALL) begin
                  addr_d  = addr_q + 18'd1;
                  state_d = S_RD_LINK;
                end else if (tbl_skip(VRAM_D)) begin
                  rd_d    = 1'b0;
                  lopr_d  = t_q;
                  state_d = S_NEXT;
                end else begin
                  addr_d  = addr_q + 18'd1;
                  idx_d   = 4'd1;
                  state_d = S_RD_BODY;
                end
              end
            end
          end

          S_RD_LINK: begin
            if (vram_ack) begin
              cmd_d[31:16] = VRAM_D;
              if (tbl_skip(cmd_q[15:0])) begin
                rd_d    = 1'b0;
                lopr_d  = t_q;
                state_d = S_NEXT;
              end else begin
                // LINK is already held, so the body starts at word 2.
                addr_d  = addr_q + 18'd1;
                idx_d   = 4'd2;
                state_d = S_RD_BODY;
              end
            end
          end

          S_RD_BODY: begin
            if (vram_ack) begin
              cmd_d[{idx_q, 4'd0} +: 16] = VRAM_D;
              if (idx_q == 4'd15) begin
                rd_d    = 1'b0;
                vld_d   = 1'b1;
                state_d = S_EMIT;
              end else begin
                addr_d  = addr_q + 18'd1;
                idx_d   = idx_q + 4'd1;
              end
            end
          end

          S_EMIT: begin
            if (CMD_READY) begin
              vld_d  = 1'b0;
              lopr_d = t_q;
              do_adv = 1'b1;
            end
          end

          S_NEXT: do_adv = 1'b1;

          default: ;  // S_IDLE waits for START
        endcase

        // Move to the next table straight from the accept cycle (or from
        // NEXT for a skipped table) so a drawn table costs 16 reads plus
        // one hand-off cycle.
        if (do_adv) begin
          t_d       = adv_t;
          stk_d     = adv_stk;
          stk_vld_d = adv_stk_vld;
          idx_d     = 4'd0;
`ifdef VDP1_CMD_LIMIT_EN
          count_d   = count_q + 16'd1;
`endif
          if (limit_hit) begin
            cef_d   = 1'b1;
            busy_d  = 1'b0;
            rd_d    = 1'b0;
            state_d = S_IDLE;
          end else begin
            copr_d  = adv_t;
            rd_d    = 1'b1;
            addr_d  = {adv_t, 2'b00};
            state_d = S_RD_CTRL;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      t_q       <= 16'h0000;
      stk_q     <= 16'h0000;
      stk_vld_q <= 1'b0;
      idx_q     <= 4'd0;
      addr_q    <= 18'd0;
      rd_q      <= 1'b0;
      drain_q   <= 1'b0;
      // NOTE: the table buffer is cleared on reset because it drives the
      // CMD output directly and that output must read as zero after reset.
      cmd_q     <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      cef_q     <= 1'b0;
      copr_q    <= 16'h0000;
      lopr_q    <= 16'h0000;
`ifdef VDP1_CMD_LIMIT_EN
      count_q   <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      stk_q     <= stk_d;
      stk_vld_q <= stk_vld_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      drain_q   <= drain_d;
      cmd_q     <= cmd_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      cef_q     <= cef_d;
      copr_q    <= copr_d;
      lopr_q    <= lopr_d;
`ifdef VDP1_CMD_LIMIT_EN
      count_q   <= count_d;
`endif
    end
  end

  assign VRAM_A    = addr_q;
  assign VRAM_RD   = rd_q;
  assign CMD       = cmd_q & CMD_MASK;
  assign CMD_VALID = vld_q;
  assign BUSY      = busy_q;
  assign CEF       = cef_q;
  assign COPR      = copr_q;
  assign LOPR      = lopr_q;

endmodule

// File: tb/tb_vdp1_cmd_fetch.sv
// ---------------------------------------------------------------------------
// tb_vdp1_cmd_fetch
//
// Bench for vdp1_cmd_fetch: a VRAM responder with programmable random ack
// delay, an emit recorder, a table of single-table walks and hand-written
// sequences for call/return, back-pressure, abort, reset and the table
// limit (VDP1_CMD_LIMIT_EN, MAX_CMDS=4).
// ---------------------------------------------------------------------------
module tb_vdp1_cmd_fetch;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         CE;
  logic         START;
  logic [17:0]  VRAM_A;
  logic         VRAM_RD;
  logic [15:0]  VRAM_D;
  logic         VRAM_RDY;
  logic [255:0] CMD;
  logic         CMD_VALID;
  logic         CMD_READY;
  logic         BUSY;
  logic         CEF;
  logic [15:0]  COPR;
  logic [15:0]  LOPR;

  vdp1_cmd_fetch #(.MAX_CMDS(16'd4)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CE        (CE),
    .START     (START),
    .VRAM_A    (VRAM_A),
    .VRAM_RD   (VRAM_RD),
    .VRAM_D    (VRAM_D),
    .VRAM_RDY  (VRAM_RDY),
    .CMD       (CMD),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .BUSY      (BUSY),
    .CEF       (CEF),
    .COPR      (COPR),
    .LOPR      (LOPR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- VRAM model ----------------
  logic [15:0] mem [0:1023];
  int          maxd   = 0;   // ack delay drawn from 0..maxd per read
  int          reads  = 0;
  int          w1_rd  = 0;   // reads of word address 1 (LINK of table 0000)
  int          wait_cnt = 0;

  initial begin
    VRAM_RDY = 1'b0;
    VRAM_D   = 16'h0000;
    forever begin
      @(posedge CLK);
      #1;
      VRAM_RDY = 1'b0;
      if (VRAM_RD) begin
        if (wait_cnt == 0) begin
          VRAM_RDY = 1'b1;
          VRAM_D   = mem[VRAM_A[9:0]];
          reads++;
          if (VRAM_A == 18'd1) w1_rd++;
          wait_cnt = (maxd == 0) ? 0 : int'($urandom_range(maxd, 0));
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // ---------------- emit recorder ----------------
  logic [15:0]  emit_t [$];
  logic [255:0] first_cmd;

  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N && CMD_VALID && CMD_READY) begin
        if (emit_t.size() == 0) first_cmd = CMD;
        emit_t.push_back(COPR);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] pat(input int n);
    return 16'hF000 | 16'(n * 16'h0111);
  endfunction

  function automatic logic [255:0] exp_cmd(input logic [15:0] ctrl,
                                           input logic [15:0] lnk);
    logic [255:0] c;
    c = '0;
    for (int n = 2; n < 16; n++) c[n*16 +: 16] = pat(n);
    c[15:0]   = ctrl & 16'hFF3F;
    c[31:16]  = lnk & 16'hFFFC;
    c[47:32]  = pat(2) & 16'h9FFF;
    c[95:80]  = pat(5) & 16'h3FFF;
    return c;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  task automatic put_table(input int t, input logic [15:0] ctrl,
                           input logic [15:0] lnk);
    mem[t*4]     = ctrl;
    mem[t*4 + 1] = lnk;
    for (int n = 2; n < 16; n++) mem[t*4 + n] = pat(n);
  endtask

  task automatic put_end(input int t);
    mem[t*4] = 16'h8000;
  endtask

  task automatic start_walk();
    emit_t.delete();
    reads = 0;
    w1_rd = 0;
    @(posedge CLK);
    #1 START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int left;
    left = budget;
    while (BUSY && left > 0) begin
      @(negedge CLK);
      left--;
    end
    check({name, " walk ends in time"}, BUSY, 1'b0);
  endtask

  // ---------------- single-table walk vectors ----------------
  typedef struct {
    logic [15:0] ctrl;
    logic [15:0] lnk;
    int          dly;
    int          emits;
    int          nreads;
    int          w1;
    logic [15:0] copr;
    logic [15:0] lopr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Table 0000 = ctrl/lnk, 0004 = END, 0040 = END.
    vecs[0] = '{16'h00C4, 16'h1237, 0, 1, 17, 1, 16'h0004, 16'h0000}; // polygon, next
    vecs[1] = '{16'h1000, 16'h0043, 3, 1, 17, 1, 16'h0040, 16'h0000}; // assign
    vecs[2] = '{16'h4000, 16'h1237, 2, 0,  2, 0, 16'h0004, 16'h0000}; // skip
    vecs[3] = '{16'h0003, 16'h1237, 0, 0,  2, 0, 16'h0004, 16'h0000}; // bad COMM 3
    vecs[4] = '{16'h0007, 16'h1237, 4, 0,  2, 0, 16'h0004, 16'h0000}; // bad COMM 7
    vecs[5] = '{16'h000A, 16'h1237, 1, 1, 17, 1, 16'h0004, 16'h0000}; // COMM A ok
    vecs[6] = '{16'h000B, 16'h1237, 0, 0,  2, 0, 16'h0004, 16'h0000}; // bad COMM B
    vecs[7] = '{16'h2001, 16'h0040, 5, 1, 17, 1, 16'h0040, 16'h0000}; // call
    vecs[8] = '{16'h3002, 16'h0040, 2, 1, 17, 1, 16'h0004, 16'h0000}; // return, empty
    vecs[9] = '{16'h6000, 16'h0040, 0, 0,  3, 1, 16'h0040, 16'h0000}; // skip + call
  end

  // Safety net against a hung walk.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] snap;
    int           rd_snap;
    int           unstable;
    int           left;

    RST_N = 1'b0;
    CE = 1'b1;
    START = 1'b0;
    CMD_READY = 1'b1;
    clear_mem();
    repeat (3) @(posedge CLK);
    #2;
    check("reset BUSY", BUSY, 1'b0);
    check("reset CEF", CEF, 1'b0);
    check("reset outputs", {CMD_VALID, VRAM_RD, VRAM_A, COPR, LOPR}, '0);
    check("reset CMD", CMD, '0);
    @(negedge CLK);
    RST_N = 1'b1;

    // CE low blocks START.
    CE = 1'b0;
    start_walk();
    @(negedge CLK);
    check("CE=0 ignores START", BUSY, 1'b0);
    CE = 1'b1;

    // ---- table-driven single-table walks ----
    for (int i = 0; i < 10; i++) begin
      clear_mem();
      put_table(0, vecs[i].ctrl, vecs[i].lnk);
      put_end(4);
      put_end('h40);
      maxd = vecs[i].dly;
      start_walk();
      wait_idle($sformatf("v%0d", i), 2000);
      check($sformatf("v%0d emits", i), emit_t.size(), vecs[i].emits);
      check($sformatf("v%0d reads", i), reads, vecs[i].nreads);
      check($sformatf("v%0d word1 reads", i), w1_rd, vecs[i].w1);
      check($sformatf("v%0d CEF", i), CEF, 1'b1);
      check($sformatf("v%0d COPR", i), COPR, vecs[i].copr);
      check($sformatf("v%0d LOPR", i), LOPR, vecs[i].lopr);
      if (vecs[i].emits > 0) begin
        check($sformatf("v%0d CMD", i), first_cmd,
              exp_cmd(vecs[i].ctrl, vecs[i].lnk));
        check($sformatf("v%0d emit addr", i), emit_t[0], 16'h0000);
      end
    end

    // ---- call into 0080, return to 0004 (END) ----
    clear_mem();
    put_table(0, 16'h2004, 16'h0080);
    put_table('h80, 16'h3004, 16'h0000);
    put_end(4);
    maxd = 2;
    start_walk();
    wait_idle("call/ret", 3000);
    check("call/ret emits", emit_t.size(), 2);
    if (emit_t.size() == 2)
      check("call/ret order", {emit_t[0], emit_t[1]}, {16'h0000, 16'h0080});
    check("call/ret reads", reads, 33);
    check("call/ret COPR", COPR, 16'h0004);
    check("call/ret LOPR", LOPR, 16'h0080);

    // ---- nested call acts as assign, return, skip at 0004, END at 0008 ----
    clear_mem();
    put_table(0, 16'h2004, 16'h0083);
    put_table('h80, 16'h2000, 16'h00C0);
    put_table('hC0, 16'h3001, 16'h0000);
    put_table(4, 16'h000C, 16'h0000);
    put_end(8);
    maxd = 1;
    start_walk();
    wait_idle("nested", 4000);
    check("nested emits", emit_t.size(), 3);
    if (emit_t.size() == 3)
      check("nested order", {emit_t[0], emit_t[1], emit_t[2]},
            {16'h0000, 16'h0080, 16'h00C0});
    check("nested reads", reads, 50);
    check("nested COPR", COPR, 16'h0008);
    check("nested LOPR", LOPR, 16'h0004);

    // ---- back-pressure, then START while the table waits ----
    clear_mem();
    put_table(0, 16'h00C5, 16'h5557);
    put_end(4);
    maxd = 5;
    CMD_READY = 1'b0;
    start_walk();
    left = 2000;
    while (!CMD_VALID && left > 0) begin
      @(negedge CLK);
      left--;
    end
    check("hold valid seen", CMD_VALID, 1'b1);
    check("hold CMD", CMD, exp_cmd(16'h00C5, 16'h5557));
    snap = CMD;
    rd_snap = reads;
    unstable = 0;
    repeat (10) begin
      @(negedge CLK);
      if (CMD !== snap || !CMD_VALID || VRAM_RD) unstable++;
    end
    check("hold stable", unstable, 0);
    check("hold no reads", reads, rd_snap);
    start_walk();
    check("abort CMD_VALID", CMD_VALID, 1'b0);
    check("abort BUSY/COPR", {BUSY, COPR}, {1'b1, 16'h0000});
    CMD_READY = 1'b1;
    wait_idle("abort restart", 2000);
    check("abort restart emits", emit_t.size(), 1);
    check("abort restart COPR", COPR, 16'h0004);

    // ---- reset in the middle of a walk ----
    clear_mem();
    put_table(0, 16'h2004, 16'h0083);
    put_table('h80, 16'h2000, 16'h00C0);
    put_table('hC0, 16'h3001, 16'h0000);
    put_end(4);
    maxd = 0;
    start_walk();
    left = 2000;
    while (COPR !== 16'h00C0 && left > 0) begin
      @(negedge CLK);
      left--;
    end
    check("mid-walk reached 00C0", COPR, 16'h00C0);
    #2 RST_N = 1'b0;
    #1;
    check("mid-walk reset regs", {BUSY, CEF, CMD_VALID, VRAM_RD, COPR, LOPR}, '0);
    check("mid-walk reset CMD", CMD, '0);
    @(negedge CLK);
    RST_N = 1'b1;

    // ---- self-looping list ----
    clear_mem();
    put_table(0, 16'h1004, 16'h0000);
    maxd = 1;
    start_walk();
`ifdef VDP1_CMD_LIMIT_EN
    wait_idle("limit", 3000);
    check("limit emits", emit_t.size(), 4);
    check("limit CEF", CEF, 1'b1);
    check("limit COPR", COPR, 16'h0000);
`else
    left = 3000;
    while (emit_t.size() < 6 && left > 0) begin
      @(negedge CLK);
      left--;
    end
    check("loop keeps emitting", emit_t.size() >= 6, 1'b1);
    check("loop still busy", {BUSY, CEF}, {1'b1, 1'b0});
    mem[0] = 16'h8000;
    start_walk();
    wait_idle("loop abort", 2000);
    check("loop abort CEF", CEF, 1'b1);
    check("loop abort emits", emit_t.size(), 0);
    check("loop abort COPR", COPR, 16'h0000);
`endif

    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
